// File: rtl/vga_scan_generator.sv
// rtl/vga_scan_generator.sv - VGA scan timing, linear pixel address and blank-gated colour output
// Pixel-rate divider, h/v counters, incremental address and a one-tick output stage for colour and syncs.
module vga_scan_generator #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  CIN,
    output logic [18:0] ADDR,
    output logic        PIX_EN,
    output logic        FRAME_START,
    output logic        HS,
    output logic        VS,
    output logic [7:0]  COLOUR_OUT
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]       V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]       HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]       HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]       VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]       VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [18:0]      ADDR_MAX = 19'(H_ACTIVE * V_ACTIVE - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic [18:0]      addr_q, addr_d;
    logic [7:0]       colour_q, colour_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             pix_en;
    logic             active;
    logic             hs_n;
    logic             vs_n;

    always_comb begin
        pix_en = (div_q == DIV_MAX) && !RESET;
        active = (h_q < H_ACT) && (v_q < V_ACT);
        hs_n   = !((h_q >= HS_START) && (h_q < HS_END));
        vs_n   = !((v_q >= VS_START) && (v_q < VS_END));
    end

    always_comb begin
        div_d    = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
        h_d      = h_q;
        v_d      = v_q;
        addr_d   = addr_q;
        colour_d = colour_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        if (pix_en) begin
            if (h_q == H_MAX) begin
                h_d = '0;
                v_d = (v_q == V_MAX) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
            // The address only advances past active pixels, so in blanking it already names the next one.
            if (active) begin
                addr_d = (addr_q == ADDR_MAX) ? '0 : addr_q + 1'b1;
            end
            colour_d = active ? CIN : 8'h00;
            hs_d     = hs_n;
            vs_d     = vs_n;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            addr_q   <= '0;
            colour_q <= 8'h00;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
        end else begin
            div_q    <= div_d;
            h_q      <= h_d;
            v_q      <= v_d;
            addr_q   <= addr_d;
            colour_q <= colour_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
        end
    end

    assign ADDR        = addr_q;
    assign PIX_EN      = pix_en;
    assign FRAME_START = pix_en && (h_q == 10'd0) && (v_q == 10'd0);
    assign HS          = hs_q;
    assign VS          = vs_q;
    assign COLOUR_OUT  = colour_q;

endmodule

// File: tb/tb_vga_scan_generator.sv
// tb/tb_vga_scan_generator.sv - randomized bench for vga_scan_generator against an arithmetic scan model
// Shrunk timing parameters keep whole frames short; the model derives position from elapsed clocks.
module tb_vga_scan_generator;

    localparam int D    = 4;
    localparam int HA   = 8;
    localparam int HFP  = 2;
    localparam int HSW  = 3;
    localparam int HBP  = 2;
    localparam int VA   = 5;
    localparam int VFP  = 1;
    localparam int VSW  = 2;
    localparam int VBP  = 2;
    localparam int HT   = HA + HFP + HSW + HBP;
    localparam int VT   = VA + VFP + VSW + VBP;
    localparam int FR   = HT * VT;

    logic        CLK;
    logic        RESET;
    logic [7:0]  CIN;
    logic [18:0] ADDR;
    logic        PIX_EN;
    logic        FRAME_START;
    logic        HS;
    logic        VS;
    logic [7:0]  COLOUR_OUT;

    vga_scan_generator #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
    ) dut (
        .CLK(CLK), .RESET(RESET), .CIN(CIN), .ADDR(ADDR), .PIX_EN(PIX_EN),
        .FRAME_START(FRAME_START), .HS(HS), .VS(VS), .COLOUR_OUT(COLOUR_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model state: clocks since reset release, and the registered outputs
    int         c = 0;
    int         cyc = 0;
    logic [7:0] m_colour = 8'h00;
    logic       m_hs = 1'b1;
    logic       m_vs = 1'b1;
    int         hs_run = 0;
    int         vs_run = 0;
    int         fs_last = 0;
    bit         fs_valid = 0;

    function automatic int addr_at(input int n);
        int x;
        int y;
        int raw;
        x = n % HT;
        y = n / HT;
        if (y >= VA) return 0;
        raw = y * HA + ((x < HA) ? x : HA);
        return (raw == HA * VA) ? 0 : raw;
    endfunction

    function automatic bit act_at(input int n);
        return ((n % HT) < HA) && ((n / HT) < VA);
    endfunction

    function automatic bit hs_at(input int n);
        int x;
        x = n % HT;
        return !((x >= HA + HFP) && (x < HA + HFP + HSW));
    endfunction

    function automatic bit vs_at(input int n);
        int y;
        y = n / HT;
        return !((y >= VA + VFP) && (y < VA + VFP + VSW));
    endfunction

    task automatic cycle();
        int  n;
        bit  rst_s;
        bit  exp_pix;
        @(posedge CLK);
        rst_s = RESET;
        cyc++;
        if (rst_s) begin
            c        = 0;
            m_colour = 8'h00;
            m_hs     = 1'b1;
            m_vs     = 1'b1;
        end else begin
            if (c % D == D - 1) begin
                n        = (c / D) % FR;
                m_colour = act_at(n) ? CIN : 8'h00;
                m_hs     = hs_at(n);
                m_vs     = vs_at(n);
            end
            c++;
        end
        #1;
        n       = (c / D) % FR;
        exp_pix = !RESET && (c % D == D - 1);
        check("pix_en", PIX_EN, exp_pix);
        check("frame_start", FRAME_START, exp_pix && (n == 0));
        check("addr", ADDR, addr_at(n));
        check("hs", HS, m_hs);
        check("vs", VS, m_vs);
        check("colour", COLOUR_OUT, m_colour);

        if (rst_s) begin
            hs_run   = 0;
            vs_run   = 0;
            fs_valid = 0;
        end
        if (HS === 1'b0) hs_run++;
        else if (hs_run > 0) begin
            check("hs_low_clks", hs_run, HSW * D);
            hs_run = 0;
        end
        if (VS === 1'b0) vs_run++;
        else if (vs_run > 0) begin
            check("vs_low_clks", vs_run, VSW * HT * D);
            vs_run = 0;
        end
        if (FRAME_START === 1'b1) begin
            if (fs_valid) check("frame_period", cyc - fs_last, FR * D);
            fs_last  = cyc;
            fs_valid = 1;
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] cin);
        @(negedge CLK);
        RESET = r;
        CIN   = cin;
        cycle();
    endtask

    initial begin
        int  k;
        bit  reached;
        RESET = 1'b1;
        CIN   = 8'hFF;

        repeat (3) drive(1'b1, 8'hFF);

        for (int i = 0; i < 2 * FR * D; i++) drive(1'b0, 8'hE3);

        for (int i = 0; i < 3 * FR * D; i++) drive(1'b0, 8'($urandom));

        for (int r = 0; r < 15; r++) begin
            int len;
            len = $urandom_range(1, 400);
            for (int i = 0; i < len; i++) drive(1'b0, 8'($urandom));
            repeat ($urandom_range(1, 2)) drive(1'b1, 8'($urandom));
        end

        // Directed mid-frame reset at the middle of the active area
        reached = 0;
        for (int i = 0; i < FR * D + 8; i++) begin
            if ((c / D) % FR == (VA / 2) * HT + HA / 2 && c % D == 1) begin
                reached = 1;
                break;
            end
            drive(1'b0, 8'($urandom));
        end
        check("reach_mid_frame", reached, 1'b1);
        drive(1'b1, 8'($urandom));
        k = 1;
        for (int i = 0; i < 2 * D; i++) begin
            drive(1'b0, 8'($urandom));
            k++;
            if (FRAME_START === 1'b1) break;
        end
        check("fs_after_reset", k, D);

        for (int i = 0; i < 2 * FR * D; i++) drive(1'b0, 8'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
